nmos_pmos: RTL and testbench
============================

// Module: nmos_pmos
// PURPOSE
//  Clocked, cycle-based model of a single CMOS stage: a P-channel pull-up network (PUN) and an
//  N-channel pull-down network (PDN), each made of N_DEV switches sharing gate inputs.
//  Resolves the stage output to 4-state logic (0/1/Z/X), registered once per cycle.
//  Sits in logic-characterisation datapaths: a NAND is PUN parallel + PDN series; a NOR is the reverse.
// PARAMETERS
//  N_DEV    2   transistors per network (1..8); device i of PUN and PDN shares gate i
//  CNT_W    16  width of contention counter
// PORTS
//  clk            in   1          single clock, rising edge
//  rst            in   1          synchronous, active-high reset
//  in_valid       in   1          evaluate this cycle
//  gate           in   2*N_DEV    encoded 4-state gate value per device, [2i+1:2i] = device i
//  pun_series     in   1          PUN topology: 0 = parallel, 1 = series
//  pdn_series     in   1          PDN topology: 0 = parallel, 1 = series
//  out_val        out  2          resolved output: 00=0, 01=1, 10=Z, 11=X
//  out_valid      out  1          out_val updated this cycle
//  contention     out  1          PUN and PDN both conducting (registered with out_val)
//  contention_cnt out  CNT_W      saturating count of contention results
// BEHAVIOUR
//  - Reset (rst=1 at posedge): out_val=Z(10), out_valid=0, contention=0, contention_cnt=0. Reset wins over in_valid.
//  - Latency 1 cycle: inputs sampled at posedge with in_valid=1 -> outputs valid after that edge; out_valid=in_valid delayed 1.
//  - in_valid=0: out_valid=0, out_val/contention hold last value.
//  - Device conduction: pmos on if gate=0, off if 1; nmos on if gate=1, off if 0; gate Z or X -> unknown.
//  - Parallel network: on if any device on; off if all off; else unknown.
//  - Series network: on if all devices on; off if any device off; else unknown.
//  - Resolution (PUN,PDN): (on,off)->1; (off,on)->0; (off,off)->Z; (on,on)->X with contention=1;
//    any unknown network that is not overridden by the rules above -> X, contention=0.
//  - contention_cnt increments by 1 on each valid contention result; saturates at all-ones, no wrap.
//  - No combinational path from any input to any output.
// CONFIGURATION
//  NMOS_PMOS_HOLD_EN defined: a Z result (both networks off) leaves out_val at the last driven 0/1
//   (charge-storage node); after reset, with no prior drive, Z is reported.
//  NMOS_PMOS_HOLD_EN undefined: Z result reported as out_val=10.
// STRUCTURE
//  Package nmos_pmos_pkg: logic4_t encoding (L0,L1,LZ,LX), conduction enum (OFF,ON,UNK), resolve function.
//  Sub-module mos_network (params N_DEV, polarity P/N): gate vector + series flag -> conduction; instantiated
//  once for PUN, once for PDN. Top holds resolution, registers, counter and hold logic.
// TESTING
//  - NAND (pun_series=0,pdn_series=1), gate(a,b)=00,01,10,11 back-to-back -> out_val 1,1,1,0 one cycle later, out_valid=1.
//  - NOR (pun_series=1,pdn_series=0), same sweep -> 1,0,0,0; contention_cnt stays 0.
//  - Contention: both parallel, gates 0,1 -> out_val=X, contention=1, contention_cnt 0->1; hold for 2^CNT_W+2 cycles -> saturates at all-ones.
//  - Unknown: NAND with a=X(11),b=1 -> X; a=X,b=0 -> 1 (PUN on via b, PDN off via b).
//  - Float: both series, gates 0,1 -> Z without macro; with NMOS_PMOS_HOLD_EN after prior 0 result -> stays 0.
//  - rst asserted mid-stream with in_valid=1 -> next cycle out_val=Z, out_valid=0, counter=0.

Source files
------------

// File: rtl/nmos_pmos_pkg.sv
// Shared types and helpers for the nmos_pmos CMOS stage model.
//   logic4_t     : 2-bit encoded 4-state value (L0=00, L1=01, LZ=10, LX=11)
//   conduction_t : network/device conduction state (OFF, ON, UNK)
//   mos_pol_t    : device polarity (POL_P pull-up, POL_N pull-down)
//   dev_cond()   : gate value -> single-device conduction for a polarity
//   resolve()    : (PUN, PDN) conduction -> output value + contention flag
package nmos_pmos_pkg;

  typedef enum logic [1:0] {
    L0 = 2'b00,
    L1 = 2'b01,
    LZ = 2'b10,
    LX = 2'b11
  } logic4_t;

  typedef enum logic [1:0] {
    OFF = 2'b00,
    ON  = 2'b01,
    UNK = 2'b10
  } conduction_t;

  typedef enum logic {
    POL_P = 1'b0,
    POL_N = 1'b1
  } mos_pol_t;

  typedef struct packed {
    logic4_t val;
    logic    cont;
  } resolved_t;

  // A P device conducts on a low gate, an N device on a high gate;
  // a floating or unknown gate leaves the device state unknown.
  function automatic conduction_t dev_cond(input logic4_t g, input mos_pol_t pol);
    conduction_t c;
    case (g)
      L0:      c = (pol == POL_P) ? ON  : OFF;
      L1:      c = (pol == POL_P) ? OFF : ON;
      default: c = UNK;
    endcase
    return c;
  endfunction

  // Any unknown network yields X without contention unless a definite
  // on/off pairing already decides the node.
  function automatic resolved_t resolve(input conduction_t pun, input conduction_t pdn);
    resolved_t r;
    r.cont = 1'b0;
    if (pun == ON && pdn == OFF)
      r.val = L1;
    else if (pun == OFF && pdn == ON)
      r.val = L0;
    else if (pun == OFF && pdn == OFF)
      r.val = LZ;
    else if (pun == ON && pdn == ON) begin
      r.val  = LX;
      r.cont = 1'b1;
    end else
      r.val = LX;
    return r;
  endfunction

endpackage

// File: rtl/nmos_pmos_network.sv
// mos_network: one switch network of N_DEV devices of a single polarity.
//   gate   in  2*N_DEV  encoded 4-state gate per device, [2i+1:2i] = device i
//   series in  1        0 = devices in parallel, 1 = devices in series
//   cond   out 2        network conduction (OFF/ON/UNK), combinational
module mos_network
  import nmos_pmos_pkg::*;
#(
  parameter int unsigned N_DEV = 2,
  parameter mos_pol_t    POL   = POL_N
) (
  input  logic [2*N_DEV-1:0] gate,
  input  logic               series,
  output conduction_t        cond
);

  logic        any_on;
  logic        any_off;
  logic        any_unk;
  conduction_t d;

  always_comb begin
    any_on  = 1'b0;
    any_off = 1'b0;
    any_unk = 1'b0;
    d       = UNK;
    for (int unsigned i = 0; i < N_DEV; i++) begin
      d = dev_cond(logic4_t'(gate[2*i +: 2]), POL);
      case (d)
        ON:      any_on  = 1'b1;
        OFF:     any_off = 1'b1;
        default: any_unk = 1'b1;
      endcase
    end
    // Series: one open switch breaks the path. Parallel: one closed switch
    // makes it. Otherwise unknowns decide.
    if (series)
      cond = any_off ? OFF : (any_unk ? UNK : ON);
    else
      cond = any_on ? ON : (any_unk ? UNK : OFF);
  end

endmodule

// File: rtl/nmos_pmos.sv
// nmos_pmos: clocked model of one CMOS stage (P pull-up + N pull-down network).
// Output resolved to 4-state logic and registered once per valid cycle.
//   clk            in   1          rising-edge clock
//   rst            in   1          synchronous active-high reset
//   in_valid       in   1          evaluate this cycle
//   gate           in   2*N_DEV    encoded gate per device, shared by PUN/PDN
//   pun_series     in   1          PUN topology (0 parallel, 1 series)
//   pdn_series     in   1          PDN topology (0 parallel, 1 series)
//   out_val        out  2          00=0, 01=1, 10=Z, 11=X
//   out_valid      out  1          out_val updated this cycle
//   contention     out  1          both networks conducting
//   contention_cnt out  CNT_W      saturating contention count
// Build option: NMOS_PMOS_HOLD_EN makes a floating (Z) result keep the last
// driven 0/1 (charge storage); without a prior drive since reset, Z is shown.
module nmos_pmos
  import nmos_pmos_pkg::*;
#(
  parameter int unsigned N_DEV = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [2*N_DEV-1:0] gate,
  input  logic               pun_series,
  input  logic               pdn_series,
  output logic [1:0]         out_val,
  output logic               out_valid,
  output logic               contention,
  output logic [CNT_W-1:0]   contention_cnt
);

  conduction_t pun_cond;
  conduction_t pdn_cond;
  resolved_t   res;
  logic4_t     val_d;
  logic4_t     val_q;
  logic        valid_q;
  logic        cont_q;
  logic [CNT_W-1:0] cnt_q;

  mos_network #(.N_DEV(N_DEV), .POL(POL_P)) u_pun (
    .gate   (gate),
    .series (pun_series),
    .cond   (pun_cond)
  );

  mos_network #(.N_DEV(N_DEV), .POL(POL_N)) u_pdn (
    .gate   (gate),
    .series (pdn_series),
    .cond   (pdn_cond)
  );

  always_comb res = resolve(pun_cond, pdn_cond);

`ifdef NMOS_PMOS_HOLD_EN
  logic    have_drive_q;
  logic4_t last_drive_q;

  always_comb begin
    val_d = res.val;
    if (res.val == LZ && have_drive_q)
      val_d = last_drive_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      have_drive_q <= 1'b0;
      last_drive_q <= L0;
    end else if (in_valid && (res.val == L0 || res.val == L1)) begin
      have_drive_q <= 1'b1;
      last_drive_q <= res.val;
    end
  end
`else
  always_comb val_d = res.val;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q   <= LZ;
      valid_q <= 1'b0;
      cont_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        val_q  <= val_d;
        cont_q <= res.cont;
        if (res.cont && cnt_q != '1)
          cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign out_val        = val_q;
  assign out_valid      = valid_q;
  assign contention     = cont_q;
  assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_nmos_pmos.sv
module tb_nmos_pmos;

  localparam int unsigned N_DEV = 2;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [3:0]       gate;
  logic             pun_series;
  logic             pdn_series;
  logic [1:0]       out_val;
  logic             out_valid;
  logic             contention;
  logic [CNT_W-1:0] contention_cnt;

  int total = 0;
  int bad   = 0;

  nmos_pmos #(.N_DEV(N_DEV), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .gate           (gate),
    .pun_series     (pun_series),
    .pdn_series     (pdn_series),
    .out_val        (out_val),
    .out_valid      (out_valid),
    .contention     (contention),
    .contention_cnt (contention_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // a = device 0, b = device 1; each 00=0 01=1 10=Z 11=X
  task automatic step(input logic ps, input logic ns, input logic [1:0] a,
                      input logic [1:0] b, input logic v);
    pun_series = ps;
    pdn_series = ns;
    gate       = {b, a};
    in_valid   = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] val, input logic vld,
                         input logic cont, input logic [CNT_W-1:0] cnt);
    chk({tag, ".val"},  32'(out_val),        32'(val));
    chk({tag, ".vld"},  32'(out_valid),      32'(vld));
    chk({tag, ".cont"}, 32'(contention),     32'(cont));
    chk({tag, ".cnt"},  32'(contention_cnt), 32'(cnt));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; gate = '0; pun_series = 1'b0; pdn_series = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_out("reset", 2'b10, 1'b0, 1'b0, 4'd0);
    rst = 1'b0;

    // NAND sweep: PUN parallel, PDN series
    step(1'b0, 1'b1, 2'b00, 2'b00, 1'b1); chk_out("nand00", 2'b01, 1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b1, 2'b00, 2'b01, 1'b1); chk_out("nand01", 2'b01, 1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b1, 2'b01, 2'b00, 1'b1); chk_out("nand10", 2'b01, 1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b1, 2'b01, 2'b01, 1'b1); chk_out("nand11", 2'b00, 1'b1, 1'b0, 4'd0);

    // NOR sweep: PUN series, PDN parallel
    step(1'b1, 1'b0, 2'b00, 2'b00, 1'b1); chk_out("nor00", 2'b01, 1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b0, 2'b00, 2'b01, 1'b1); chk_out("nor01", 2'b00, 1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b0, 2'b01, 2'b00, 1'b1); chk_out("nor10", 2'b00, 1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b0, 2'b01, 2'b01, 1'b1); chk_out("nor11", 2'b00, 1'b1, 1'b0, 4'd0);

    // idle cycle: inputs that would give 1 must not be taken
    step(1'b1, 1'b0, 2'b00, 2'b00, 1'b0); chk_out("idle", 2'b00, 1'b0, 1'b0, 4'd0);

    // unknown gates on a NAND
    step(1'b0, 1'b1, 2'b11, 2'b01, 1'b1); chk_out("nandX1", 2'b11, 1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b1, 2'b11, 2'b00, 1'b1); chk_out("nandX0", 2'b01, 1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b1, 2'b10, 2'b01, 1'b1); chk_out("nandZ1", 2'b11, 1'b1, 1'b0, 4'd0);

    // drive a 0, then float both networks
    step(1'b1, 1'b0, 2'b01, 2'b01, 1'b1); chk_out("pre0", 2'b00, 1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b1, 2'b00, 2'b01, 1'b1);
`ifdef NMOS_PMOS_HOLD_EN
    chk_out("float", 2'b00, 1'b1, 1'b0, 4'd0);
`else
    chk_out("float", 2'b10, 1'b1, 1'b0, 4'd0);
`endif

    // contention: both parallel, a=0 turns PUN on, b=1 turns PDN on
    step(1'b0, 1'b0, 2'b00, 2'b01, 1'b1); chk_out("cont1", 2'b11, 1'b1, 1'b1, 4'd1);
    step(1'b0, 1'b0, 2'b00, 2'b01, 1'b1); chk_out("cont2", 2'b11, 1'b1, 1'b1, 4'd2);
    // idle does not count
    step(1'b0, 1'b0, 2'b00, 2'b01, 1'b0); chk_out("contidle", 2'b11, 1'b0, 1'b1, 4'd2);
    for (int i = 0; i < 14; i++)
      step(1'b0, 1'b0, 2'b00, 2'b01, 1'b1);
    chk_out("cont_max", 2'b11, 1'b1, 1'b1, 4'd15);
    step(1'b0, 1'b0, 2'b00, 2'b01, 1'b1);
    step(1'b0, 1'b0, 2'b00, 2'b01, 1'b1);
    chk_out("cont_sat", 2'b11, 1'b1, 1'b1, 4'd15);

    // reset mid-stream wins over in_valid
    rst = 1'b1;
    step(1'b0, 1'b0, 2'b00, 2'b01, 1'b1); chk_out("midrst", 2'b10, 1'b0, 1'b0, 4'd0);
    rst = 1'b0;

    // float straight after reset: no prior drive, Z in either build
    step(1'b1, 1'b1, 2'b00, 2'b01, 1'b1); chk_out("float_rst", 2'b10, 1'b1, 1'b0, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
